// File: rtl/cordic_mmio_ctrl_if.sv
// TinyQV peripheral-slot bus: one access per cycle, data_ready always high.
interface cordic_mmio_ctrl_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/cordic_mmio_ctrl.sv
// CPU register front-end for the CORDIC engine: launches one run per START write, watchdogs it, captures results.
// Reads are combinational, writes take effect on the next edge; the bus never stalls (data_ready tied high).
module cordic_mmio_ctrl #(
  parameter int FIXED_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_mmio_ctrl_if.slave      bus,
  output logic                   user_interrupt,
  output logic                   eng_start,
  output logic                   eng_is_rotating,
  output logic [1:0]             eng_mode,
  output logic [3:0]             eng_alpha,
  output logic [FIXED_WIDTH-1:0] eng_A,
  output logic [FIXED_WIDTH-1:0] eng_B,
  input  logic [FIXED_WIDTH-1:0] eng_out1,
  input  logic [FIXED_WIDTH-1:0] eng_out2,
  input  logic                   eng_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:1]  ctrl_q, ctrl_d;
  logic [31:0] ops_q, ops_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;

  logic        wr_en, rd_en;
  logic [3:0]  reg_sel;
  logic        wr_ctrl, wr_ops, wr_stat, start_wr;
  logic [31:0] ctrl_wr;
  logic [31:0] rdata;
  logic        unused_bits;

  // Byte/half/word write: merge new data into the held register under a lane mask.
  function automatic logic [31:0] merge_wr(input logic [31:0] old_val,
                                           input logic [31:0] wdat,
                                           input logic [1:0]  wr_n);
    logic [31:0] mask;
    case (wr_n)
      2'b00:   mask = 32'h0000_00ff;
      2'b01:   mask = 32'h0000_ffff;
      2'b10:   mask = 32'hffff_ffff;
      default: mask = 32'h0000_0000;
    endcase
    return (old_val & ~mask) | (wdat & mask);
  endfunction

  assign wr_en    = (bus.data_write_n != 2'b11);
  assign rd_en    = (bus.data_read_n != 2'b11);
  assign reg_sel  = bus.address[5:2];
  assign wr_ctrl  = wr_en && (reg_sel == 4'd0);
  assign wr_ops   = wr_en && (reg_sel == 4'd1);
  assign wr_stat  = wr_en && (reg_sel == 4'd3);
  assign start_wr = wr_ctrl && bus.data_in[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    ops_d     = ops_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    eng_start = 1'b0;
    ctrl_wr   = merge_wr({23'b0, ctrl_q, 1'b0}, bus.data_in, bus.data_write_n);

    if (wr_ctrl) ctrl_d = ctrl_wr[8:1];
    if (wr_ops)  ops_d  = merge_wr(ops_q, bus.data_in, bus.data_write_n);
    if (wr_stat) begin
      done_d = done_q & ~bus.data_in[1];
      err_d  = err_q  & ~bus.data_in[2];
      ovr_d  = ovr_q  & ~bus.data_in[3];
    end

    // Set events are applied after the W1C clears so a same-cycle set wins.
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d = ST_LAUNCH;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      ST_LAUNCH: begin
        eng_start = 1'b1;
        cnt_d     = 8'd0;
        state_d   = ST_WAIT;
        if (start_wr) ovr_d = 1'b1;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (start_wr) ovr_d = 1'b1;
        if (eng_done) begin
          result_d = {16'(eng_out2), 16'(eng_out1)};
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      ops_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      ops_q    <= ops_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      4'd0:    rdata = {23'b0, ctrl_q, 1'b0};
      4'd1:    rdata = ops_q;
      4'd2:    rdata = result_q;
      4'd3:    rdata = {28'b0, ovr_q, err_q, done_q, (state_q != ST_IDLE)};
      default: rdata = 32'h0;
    endcase
  end

  assign bus.data_out    = rd_en ? rdata : 32'h0;
  assign bus.data_ready  = 1'b1;
  assign user_interrupt  = ctrl_q[8] & (done_q | err_q);
  assign eng_is_rotating = ctrl_q[1];
  assign eng_mode        = ctrl_q[3:2];
  assign eng_alpha       = ctrl_q[7:4];
  assign eng_A           = ops_q[FIXED_WIDTH-1:0];
  assign eng_B           = ops_q[16 +: FIXED_WIDTH];

  assign unused_bits = &{1'b0, ctrl_wr[31:9], ctrl_wr[0], bus.address[1:0]};

endmodule

// File: tb/tb_cordic_mmio_ctrl.sv
// Directed bench for cordic_mmio_ctrl: register-map vector table plus cycle-exact run sequences.
module tb_cordic_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        user_interrupt, eng_start, eng_is_rotating, eng_done;
  logic [1:0]  eng_mode;
  logic [3:0]  eng_alpha;
  logic [15:0] eng_A, eng_B, eng_out1, eng_out2;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;

  cordic_mmio_ctrl_if bus();

  cordic_mmio_ctrl #(.FIXED_WIDTH(16), .TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .user_interrupt(user_interrupt), .eng_start(eng_start),
    .eng_is_rotating(eng_is_rotating), .eng_mode(eng_mode), .eng_alpha(eng_alpha),
    .eng_A(eng_A), .eng_B(eng_B), .eng_out1(eng_out1), .eng_out2(eng_out2),
    .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  typedef struct {
    string       name;
    logic [5:0]  addr;
    logic [31:0] wdat;
    logic [1:0]  wr_n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = w;
    tick();
    bus.data_write_n = 2'b11;
    bus.data_in      = 32'h0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    bus.address     = a;
    bus.data_read_n = 2'b00;
    #1;
    d = bus.data_out;
    bus.data_read_n = 2'b11;
  endtask

  task automatic chk_rd(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    bus.address = 6'h0; bus.data_in = 32'h0;
    bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
    eng_done = 1'b0; eng_out1 = 16'h0; eng_out2 = 16'h0;

    vecs[0]  = '{"ops_word",      6'h04, 32'h1234_5678, 2'b10, 32'h1234_5678};
    vecs[1]  = '{"ops_byte",      6'h04, 32'hAABB_CCEE, 2'b00, 32'h1234_56EE};
    vecs[2]  = '{"ops_half",      6'h04, 32'h9999_BEEF, 2'b01, 32'h1234_BEEF};
    vecs[3]  = '{"ops_word2",     6'h04, 32'h0040_0100, 2'b10, 32'h0040_0100};
    vecs[4]  = '{"ctrl_word",     6'h00, 32'hFFFF_FFFE, 2'b10, 32'h0000_01FE};
    vecs[5]  = '{"ctrl_byte",     6'h00, 32'h0000_0000, 2'b00, 32'h0000_0100};
    vecs[6]  = '{"ctrl_half",     6'h00, 32'hFFFF_0006, 2'b01, 32'h0000_0006};
    vecs[7]  = '{"result_ro",     6'h08, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000};
    vecs[8]  = '{"unmapped_10",   6'h10, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000};
    vecs[9]  = '{"unmapped_3c",   6'h3C, 32'h0,         2'b11, 32'h0000_0000};
    vecs[10] = '{"addr_lsb_ign",  6'h07, 32'h0,         2'b11, 32'h0040_0100};
    vecs[11] = '{"status_w1c_0",  6'h0C, 32'h0000_000F, 2'b10, 32'h0000_0000};

    // Reset: two cycles low, everything reads zero.
    tick(); tick();
    rst_n = 1'b1;
    chk_rd("rst_ctrl",   6'h00, 32'h0);
    chk_rd("rst_ops",    6'h04, 32'h0);
    chk_rd("rst_result", 6'h08, 32'h0);
    chk_rd("rst_status", 6'h0C, 32'h0);
    chk("rst_irq",   {31'b0, user_interrupt}, 32'h0);
    chk("rst_start", {31'b0, eng_start}, 32'h0);
    chk("rst_engA",  {16'b0, eng_A}, 32'h0);
    chk("rst_ready", {31'b0, bus.data_ready}, 32'h1);
    tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr_n != 2'b11) wr(vecs[i].addr, vecs[i].wdat, vecs[i].wr_n);
      chk_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
      tick();
    end
    chk("eng_A", {16'b0, eng_A}, 32'h0000_0100);
    chk("eng_B", {16'b0, eng_B}, 32'h0000_0040);

    // Normal run: done 10 cycles after the start pulse, DONE readable 12 cycles after the write.
    s0 = start_cnt;
    wr(6'h00, 32'h0000_0107, 2'b10);
    chk("run_start",  {31'b0, eng_start}, 32'h1);
    chk("run_mode",   {30'b0, eng_mode}, 32'h1);
    chk("run_rot",    {31'b0, eng_is_rotating}, 32'h1);
    chk_rd("run_busy", 6'h0C, 32'h1);
    repeat (10) tick();
    eng_done = 1'b1; eng_out1 = 16'h1234; eng_out2 = 16'hABCD;
    chk_rd("run_busy_at_done", 6'h0C, 32'h1);
    tick();
    eng_done = 1'b0;
    chk_rd("run_result", 6'h08, 32'hABCD_1234);
    chk_rd("run_status", 6'h0C, 32'h2);
    chk("run_irq", {31'b0, user_interrupt}, 32'h1);
    chk("run_pulses", start_cnt - s0, 32'd1);
    wr(6'h0C, 32'h0000_0002, 2'b10);
    chk("run_irq_clr", {31'b0, user_interrupt}, 32'h0);
    chk_rd("run_status_clr", 6'h0C, 32'h0);

    // Overrun: START again 3 cycles into WAIT, fields still update.
    s0 = start_cnt;
    wr(6'h00, 32'h0000_0107, 2'b10);
    repeat (3) tick();
    wr(6'h00, 32'h0000_01F5, 2'b10);
    chk_rd("ovr_status_busy", 6'h0C, 32'h9);
    chk("ovr_alpha", {28'b0, eng_alpha}, 32'hF);
    chk("ovr_rot",   {31'b0, eng_is_rotating}, 32'h0);
    repeat (6) tick();
    eng_done = 1'b1; eng_out1 = 16'h1111; eng_out2 = 16'h2222;
    tick();
    eng_done = 1'b0;
    chk_rd("ovr_status_done", 6'h0C, 32'hA);
    chk_rd("ovr_result", 6'h08, 32'h2222_1111);
    chk("ovr_pulses", start_cnt - s0, 32'd1);

    // Timeout: no done; ERR appears exactly 64 cycles after the start pulse.
    wr(6'h00, 32'h0000_0107, 2'b10);
    chk("to_start", {31'b0, eng_start}, 32'h1);
    repeat (63) tick();
    chk_rd("to_still_busy", 6'h0C, 32'h1);
    chk("to_no_irq_yet", {31'b0, user_interrupt}, 32'h0);
    tick();
    chk_rd("to_status", 6'h0C, 32'h4);
    chk_rd("to_result_held", 6'h08, 32'h2222_1111);
    chk("to_irq", {31'b0, user_interrupt}, 32'h1);

    // START and eng_done together in IDLE: launch wins, done ignored.
    eng_done = 1'b1; eng_out1 = 16'h5555; eng_out2 = 16'h6666;
    wr(6'h00, 32'h0000_0107, 2'b10);
    eng_done = 1'b0;
    chk_rd("race_idle_status", 6'h0C, 32'h1);
    chk_rd("race_idle_result", 6'h08, 32'h2222_1111);
    tick(); tick();
    // W1C of DONE in the same cycle as eng_done: DONE must stay set.
    eng_done = 1'b1; eng_out1 = 16'h7777; eng_out2 = 16'h8888;
    wr(6'h0C, 32'h0000_0002, 2'b10);
    eng_done = 1'b0;
    chk_rd("w1c_race_status", 6'h0C, 32'h2);
    chk_rd("w1c_race_result", 6'h08, 32'h8888_7777);
    wr(6'h0C, 32'h0000_0004, 2'b10);
    chk_rd("w1c_err_only", 6'h0C, 32'h2);

    // Reset during WAIT, then a stray done two cycles later.
    s0 = start_cnt;
    wr(6'h00, 32'h0000_0107, 2'b10);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_rd("rstmid_status", 6'h0C, 32'h0);
    tick(); tick();
    eng_done = 1'b1; eng_out1 = 16'h9999; eng_out2 = 16'h9999;
    tick();
    eng_done = 1'b0;
    chk_rd("rstmid_status_after_done", 6'h0C, 32'h0);
    chk_rd("rstmid_result", 6'h08, 32'h0);
    chk("rstmid_irq", {31'b0, user_interrupt}, 32'h0);
    chk("rstmid_pulses", start_cnt - s0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_mmio_ctrl.md
# cordic_mmio_ctrl

Memory-mapped front-end that sits directly upstream of the CORDIC engine inside the TinyQV peripheral slot. It holds the operand and command registers written by the CPU, issues a single-cycle start pulse to the engine, and supervises the run with a watchdog. When the engine signals done it captures both results, sets a sticky status flag and optionally raises the peripheral interrupt.

## Interface
Parameters:
- FIXED_WIDTH, 16: engine operand/result width. Must be ≤16 so A/B pack into one word.
- TIMEOUT_CYCLES, 63: maximum cycles spent in WAIT before the run is abandoned. Range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- address  in  6  byte address within peripheral; bits [1:0] ignored
- data_in  in  32  CPU write data
- data_write_n  in  2  11 = none, 00 = byte, 01 = half, 10 = word
- data_read_n  in  2  11 = none, otherwise read
- data_out  out  32  read data, combinational mux of addressed register
- data_ready  out  1  tied 1; every access completes in its own cycle
- user_interrupt  out  1  level interrupt
- eng_start  out  1  one-cycle launch pulse to engine
- eng_is_rotating  out  1  from CTRL[1]
- eng_mode  out  2  from CTRL[3:2]
- eng_alpha  out  4  from CTRL[7:4]; Z-scale "1.0" shift
- eng_A, eng_B  out  FIXED_WIDTH each  from OPERANDS
- eng_out1, eng_out2  in  FIXED_WIDTH each  engine results
- eng_done  in  1  engine one-cycle completion pulse

## Operation
- Register map (word offsets):
  - 0x00 CTRL: [0] START (write-only, reads 0), [1] ROT, [3:2] MODE, [7:4] ALPHA, [8] IRQ_EN.
  - 0x04 OPERANDS: [15:0] A, [31:16] B.
  - 0x08 RESULT (read-only): [15:0] OUT1, [31:16] OUT2.
  - 0x0C STATUS: [0] BUSY (RO), [1] DONE (W1C), [2] ERR (W1C), [3] OVR (W1C).
  - Other offsets read 0; writes ignored.
- Writes honour width: byte updates bits [7:0], half updates [15:0], word updates [31:0]; remaining bits are held.
- The eng_* command/operand outputs are driven continuously from CTRL/OPERANDS. Because the engine latches at start, the CPU may rewrite operands while BUSY to stage the next run.
- FSM:
  - IDLE: a write to CTRL with data_in[0]=1 goes to LAUNCH. The same write updates the CTRL fields and clears DONE, ERR and OVR.
  - LAUNCH: eng_start=1 for this single cycle. Clear the watchdog counter. Go to WAIT.
  - WAIT: count up each cycle. On eng_done, latch eng_out1/eng_out2 into RESULT, set DONE and go to IDLE. Otherwise, when the count equals TIMEOUT_CYCLES, set ERR, leave RESULT unchanged and go to IDLE.
- BUSY = (state != IDLE).
- START written in LAUNCH or WAIT: no effect on the FSM; sets OVR. The CTRL field bits are still updated.
- eng_done seen in IDLE or LAUNCH: ignored.
- user_interrupt = IRQ_EN & (DONE | ERR).
- Result width rule: FIXED_WIDTH < 16 zero-extends each field into its 16-bit slot. A/B outputs take the low FIXED_WIDTH bits of each slot.

## Timing
- Reset values: all registers 0, state IDLE. data_out=0, user_interrupt=0, eng_start=0, eng_* outputs 0. data_ready=1.
- Reset asserted mid-run returns the block to IDLE on the next edge. A later stray eng_done is ignored.
- START write in cycle N: eng_start is high in cycle N+1 only. BUSY reads 1 from cycle N+1.
- eng_done in cycle M: RESULT, DONE, IRQ and BUSY=0 are all visible from cycle M+1.
- With a 9-iteration engine (done 10 cycles after its start edge), the total from START write to DONE readable is 12 cycles.
- Simultaneous W1C write and set event in the same cycle: the set wins and the flag stays 1.
- Simultaneous START write and eng_done in IDLE: the launch proceeds and eng_done is ignored.
- Watchdog: ERR is set exactly TIMEOUT_CYCLES+1 cycles after eng_start, if no done has arrived.

## Test plan
- Reset: hold rst_n low 2 cycles, then read all offsets. Every read returns 0, user_interrupt=0, eng_start=0.
- Normal run with stub engine (done 10 cycles after start; out1=0x1234, out2=0xABCD):
  - Write OPERANDS=0x00400100, then CTRL=0x00000107.
  - Required: eng_start is a single pulse, eng_mode=01, eng_is_rotating=1.
  - RESULT reads 0xABCD1234, STATUS reads 0x2, user_interrupt=1.
  - Writing STATUS=0x2 drops the interrupt.
- Overrun: write START again 3 cycles into WAIT. Required: no second eng_start pulse, STATUS=0x9 while busy, then 0xA after done.
- Timeout: stub never asserts done, TIMEOUT_CYCLES=63. Required: BUSY clears and ERR=1 exactly 64 cycles after eng_start, RESULT unchanged, interrupt raised if IRQ_EN=1.
- W1C race: write STATUS=0x2 in the same cycle as eng_done (DONE already set from a previous run). Required: DONE remains 1.
- Partial writes and reset mid-run:
  - Byte write 0xEE to OPERANDS: only bits [7:0] change.
  - Assert rst_n during WAIT: state returns to IDLE. A stub eng_done 2 cycles later leaves STATUS=0.
